// File: rtl/distance_constraint_solver.sv
// Distance-constraint solver: pulls two rope/cloth nodes back to a fixed rest length.
// Latency: 2*WIDTH+3 cycles from accept to done (WIDTH+2 on the pass-through path).
// Single request in flight: start is only sampled while idle and is dropped while busy.
module distance_constraint_solver #(
    parameter int               WIDTH    = 32,
    parameter int               FRAC     = 20,
    parameter logic [WIDTH-1:0] REST_LEN = 32'h00A00000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pin_a,
    input  logic             pin_b,
    input  logic [WIDTH-1:0] ax_in,
    input  logic [WIDTH-1:0] ay_in,
    input  logic [WIDTH-1:0] bx_in,
    input  logic [WIDTH-1:0] by_in,
    output logic             busy,
    output logic             done,
    output logic             skip,
    output logic [WIDTH-1:0] ax_out,
    output logic [WIDTH-1:0] ay_out,
    output logic [WIDTH-1:0] bx_out,
    output logic [WIDTH-1:0] by_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(2 * WIDTH);
    localparam logic [SW-1:0]    SH_ONE  = SW'(FRAC);
    localparam logic [SW-1:0]    SH_HALF = SW'(FRAC + 1);
    localparam logic [WIDTH-1:0] RMAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] RMIN    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQRT,
        S_CHECK,
        S_DIV,
        S_APPLY
    } state_t;

    state_t state;

    // captured request
    logic [WIDTH-1:0] ax_r, ay_r, bx_r, by_r;
    logic             pa_r, pb_r;

    // geometry
    logic [WIDTH-1:0]   dx_r, dy_r;
    logic [2*WIDTH-1:0] rad;
    logic               range_r;

    // square root / divide working registers
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] sq_rem;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_q;
    logic             div_ovf;
    logic             neg_r;
    logic [CW-1:0]    cnt;

    // combinational helpers
    logic [WIDTH-1:0]          dx_c, dy_c;
    logic [2*WIDTH-1:0]        dx_ext, dy_ext, sum_c;
    logic                      range_c;
    logic [WIDTH+1:0]          sq_sh, sq_trial;
    logic                      sq_ge;
    logic [WIDTH:0]            div_sh;
    logic                      div_ge;
    logic [WIDTH-1:0]          mag_c;
    logic                      neg_c;
    logic [2*WIDTH-1:0]        num_c;
    logic [WIDTH-1:0]          ratio;
    logic signed [2*WIDTH-1:0] dxr_ext, dyr_ext, rat_ext, px, py;
    logic [SW-1:0]             sh;
    logic [WIDTH-1:0]          cx, cy;
    logic [WIDTH-1:0]          ax_new, ay_new, bx_new, by_new;

    // Datapath for every phase; the FSM picks which results it registers.
    always_comb begin
        // LOAD: separation vector and its squared length
        dx_c   = bx_r - ax_r;
        dy_c   = by_r - ay_r;
        dx_ext = {{WIDTH{dx_c[WIDTH-1]}}, dx_c};
        dy_ext = {{WIDTH{dy_c[WIDTH-1]}}, dy_c};
        sum_c  = dx_ext * dx_ext + dy_ext * dy_ext;
        // |v| >= 2^(WIDTH-2) raw exactly when the top two bits differ
        range_c = (dx_c[WIDTH-1] ^ dx_c[WIDTH-2]) | (dy_c[WIDTH-1] ^ dy_c[WIDTH-2]);

        // SQRT: bring down two radicand bits, try subtracting 4*root+1
        sq_sh    = {sq_rem, rad[2*WIDTH-1:2*WIDTH-2]};
        sq_trial = {root, 2'b01};
        sq_ge    = (sq_sh >= sq_trial);

        // DIV: bring down one dividend bit, try subtracting the divisor
        div_sh = {div_rem, div_q[WIDTH-1]};
        div_ge = (div_sh >= {1'b0, root});

        // CHECK: signed (d - REST_LEN) split into magnitude and sign
        if (root >= REST_LEN) begin
            mag_c = root - REST_LEN;
            neg_c = 1'b0;
        end else begin
            mag_c = REST_LEN - root;
            neg_c = 1'b1;
        end
        num_c = {{WIDTH{1'b0}}, mag_c} << FRAC;

        // APPLY: restore sign and saturate the quotient to a signed WIDTH value
        if (!neg_r) begin
            ratio = (div_ovf || div_q[WIDTH-1]) ? RMAX : div_q;
        end else begin
            ratio = (div_ovf || (div_q > RMIN)) ? RMIN : ('0 - div_q);
        end
        dxr_ext = {{WIDTH{dx_r[WIDTH-1]}}, dx_r};
        dyr_ext = {{WIDTH{dy_r[WIDTH-1]}}, dy_r};
        rat_ext = {{WIDTH{ratio[WIDTH-1]}}, ratio};
        px      = dxr_ext * rat_ext;
        py      = dyr_ext * rat_ext;
        // a single free node takes the whole correction, two free nodes split it
        sh      = (pa_r ^ pb_r) ? SH_ONE : SH_HALF;
        cx      = WIDTH'(px >>> sh);
        cy      = WIDTH'(py >>> sh);
        ax_new  = pa_r ? ax_r : ax_r + cx;
        ay_new  = pa_r ? ay_r : ay_r + cy;
        bx_new  = pb_r ? bx_r : bx_r - cx;
        by_new  = pb_r ? by_r : by_r - cy;
    end

    // Sequencer: capture, measure, divide, apply; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            skip    <= 1'b0;
            ax_out  <= '0;
            ay_out  <= '0;
            bx_out  <= '0;
            by_out  <= '0;
            ax_r    <= '0;
            ay_r    <= '0;
            bx_r    <= '0;
            by_r    <= '0;
            pa_r    <= 1'b0;
            pb_r    <= 1'b0;
            dx_r    <= '0;
            dy_r    <= '0;
            rad     <= '0;
            range_r <= 1'b0;
            root    <= '0;
            sq_rem  <= '0;
            div_rem <= '0;
            div_q   <= '0;
            div_ovf <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ax_r  <= ax_in;
                        ay_r  <= ay_in;
                        bx_r  <= bx_in;
                        by_r  <= by_in;
                        pa_r  <= pin_a;
                        pb_r  <= pin_b;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dx_r    <= dx_c;
                    dy_r    <= dy_c;
                    rad     <= sum_c;
                    range_r <= range_c;
                    root    <= '0;
                    sq_rem  <= '0;
                    cnt     <= '0;
                    state   <= S_SQRT;
                end
                S_SQRT: begin
                    rad    <= {rad[2*WIDTH-3:0], 2'b00};
                    // remainder stays below 2^WIDTH for every step that reuses it
                    sq_rem <= WIDTH'(sq_ge ? (sq_sh - sq_trial) : sq_sh);
                    root   <= {root[WIDTH-2:0], sq_ge};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((root == '0) || range_r) begin
                        ax_out <= ax_r;
                        ay_out <= ay_r;
                        bx_out <= bx_r;
                        by_out <= by_r;
                        skip   <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        div_rem <= num_c[2*WIDTH-1:WIDTH];
                        div_q   <= num_c[WIDTH-1:0];
                        // quotient would need more than WIDTH bits
                        div_ovf <= (num_c[2*WIDTH-1:WIDTH] >= root);
                        neg_r   <= neg_c;
                        cnt     <= '0;
                        state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    div_rem <= WIDTH'(div_ge ? (div_sh - {1'b0, root}) : div_sh);
                    div_q   <= {div_q[WIDTH-2:0], div_ge};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    ax_out <= ax_new;
                    ay_out <= ay_new;
                    bx_out <= bx_new;
                    by_out <= by_new;
                    skip   <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
